// File: rtl/exec_sequencer.sv
// rtl/exec_sequencer.sv - run/step/halt sequencer and register-file read-port arbiter
//
// Gates execution of the single-cycle datapath into one-cycle tick enables.
// Ports:
//   clock, reset             system clock, asynchronous active-low reset
//   run_req, step_req        free-run level, step button level (rising edge = one instruction)
//   halt_req, clr_req        stop to IDLE, release HALT
//   dis_req, disp_add        display request and register index for the shared read port
//   inst_rs, pc              datapath rs field and current program counter
//   tick                     one-cycle execute enable
//   dis, rf_rd_addr          display grant and arbitrated register-file read address
//   state, done, retired     FSM state, HALT flag, saturating instruction count
module exec_sequencer #(
    parameter int DIV     = 50000000,
    parameter int PC_W    = 5,
    parameter int LAST_PC = 31
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            run_req,
    input  logic            step_req,
    input  logic            halt_req,
    input  logic            clr_req,
    input  logic            dis_req,
    input  logic [PC_W-1:0] disp_add,
    input  logic [PC_W-1:0] inst_rs,
    input  logic [PC_W-1:0] pc,
    output logic            tick,
    output logic            dis,
    output logic [PC_W-1:0] rf_rd_addr,
    output logic [1:0]      state,
    output logic            done,
    output logic [7:0]      retired
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);
    localparam logic [PC_W-1:0]  PC_LAST = PC_W'(LAST_PC);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_STEP = 2'b10,
        S_HALT = 2'b11
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              step_q;
    logic              dis_q, dis_d;
    logic [7:0]        retired_q;
    logic              step_rise;
    logic              cnt_top;
    logic              pc_last;

    assign step_rise = step_req & ~step_q;
    assign cnt_top   = (cnt_q == CNT_MAX);
    assign pc_last   = (pc == PC_LAST);

    // Decoded from registers only so the enable cannot glitch.
    assign tick = ((state_q == S_RUN) && cnt_top) || (state_q == S_STEP);
    assign done = (state_q == S_HALT);

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            S_IDLE: begin
                if (halt_req)       state_d = S_IDLE;
                else if (step_rise) state_d = S_STEP;
                else if (run_req)   state_d = S_RUN;
            end
            S_RUN: begin
                if (halt_req)               state_d = S_IDLE;
                else if (cnt_top && pc_last) state_d = S_HALT;
                else if (!run_req)          state_d = S_IDLE;
                else                        cnt_d = cnt_top ? '0 : cnt_q + CNT_W'(1);
            end
            S_STEP: begin
                // A step already entered always completes, even under halt_req.
                state_d = pc_last ? S_HALT : S_IDLE;
            end
            S_HALT: begin
                if (clr_req) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // The display may only own the read port in states that never tick.
    assign dis_d = dis_req & ((state_d == S_IDLE) || (state_d == S_HALT));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            step_q    <= 1'b0;
            dis_q     <= 1'b0;
            retired_q <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            step_q  <= step_req;
            dis_q   <= dis_d;
            if (tick && (retired_q != 8'hFF))
                retired_q <= retired_q + 8'd1;
        end
    end

    assign dis        = dis_q;
    assign rf_rd_addr = dis_q ? disp_add : inst_rs;
    assign state      = state_q;
    assign retired    = retired_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// tb/tb_exec_sequencer.sv - directed self-checking bench for exec_sequencer
module tb_exec_sequencer;

    logic       clock = 1'b0;
    logic       reset, run_req, step_req, halt_req, clr_req, dis_req;
    logic [4:0] disp_add, inst_rs, pc;
    logic       tick, dis, done;
    logic [4:0] rf_rd_addr;
    logic [1:0] state;
    logic [7:0] retired;

    int   tests = 0;
    int   fails = 0;
    int   ntick = 0;
    logic pc_inc = 1'b0;

    exec_sequencer #(.DIV(4), .PC_W(5), .LAST_PC(3)) dut (
        .clock(clock), .reset(reset), .run_req(run_req), .step_req(step_req),
        .halt_req(halt_req), .clr_req(clr_req), .dis_req(dis_req),
        .disp_add(disp_add), .inst_rs(inst_rs), .pc(pc),
        .tick(tick), .dis(dis), .rf_rd_addr(rf_rd_addr), .state(state),
        .done(done), .retired(retired)
    );

    always #5 clock = ~clock;

    // One clock: sample tick before the edge, model the PC advancing on tick.
    task automatic cyc();
        logic t;
        t = tick;
        @(posedge clock);
        #1;
        if (t) begin
            ntick++;
            if (pc_inc) pc = pc + 5'd1;
        end
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cyc();
        cyc();
        reset = 1'b1;
        ntick = 0;
    endtask

    task automatic test_reset();
        reset = 1'b0; run_req = 0; step_req = 0; halt_req = 0; clr_req = 0; dis_req = 0;
        disp_add = 5'd0; inst_rs = 5'd0; pc = 5'd0;
        @(negedge clock);
        @(negedge clock);
        tests++; if (state !== 2'b00) begin fails++; $display("FAIL reset_state got %b exp 00", state); end
        tests++; if (tick !== 1'b0) begin fails++; $display("FAIL reset_tick got %b exp 0", tick); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b exp 0", done); end
        tests++; if (dis !== 1'b0) begin fails++; $display("FAIL reset_dis got %b exp 0", dis); end
        tests++; if (retired !== 8'd0) begin fails++; $display("FAIL reset_retired got %0d exp 0", retired); end
        reset = 1'b1;
    endtask

    task automatic test_run();
        logic [11:0] pat;
        logic        dis_seen;
        pat = '0; dis_seen = 1'b0;
        pc = 5'd0; pc_inc = 1'b1; ntick = 0;
        dis_req = 1'b1; disp_add = 5'd7; inst_rs = 5'd12;
        run_req = 1'b1;
        cyc();
        for (int i = 0; i < 12; i++) begin
            pat[i] = tick;
            if (dis) dis_seen = 1'b1;
            cyc();
        end
        tests++; if (pat !== 12'h888) begin fails++; $display("FAIL run_tick_pattern got %h exp 888", pat); end
        tests++; if (retired !== 8'd3) begin fails++; $display("FAIL run_retired got %0d exp 3", retired); end
        tests++; if (state !== 2'b01) begin fails++; $display("FAIL run_state got %b exp 01", state); end
        tests++; if (dis_seen !== 1'b0) begin fails++; $display("FAIL run_dis got %b exp 0", dis_seen); end
    endtask

    task automatic test_last_pc();
        repeat (4) cyc();
        repeat (8) cyc();
        tests++; if (state !== 2'b11) begin fails++; $display("FAIL halt_state got %b exp 11", state); end
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL halt_done got %b exp 1", done); end
        tests++; if (ntick !== 4) begin fails++; $display("FAIL halt_ticks got %0d exp 4", ntick); end
        tests++; if (retired !== 8'd4) begin fails++; $display("FAIL halt_retired got %0d exp 4", retired); end
        tests++; if (dis !== 1'b1) begin fails++; $display("FAIL halt_dis got %b exp 1", dis); end
        run_req = 1'b0; clr_req = 1'b1;
        cyc();
        clr_req = 1'b0;
        tests++; if (state !== 2'b00) begin fails++; $display("FAIL clr_state got %b exp 00", state); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL clr_done got %b exp 0", done); end
        pc_inc = 1'b0; pc = 5'd0; dis_req = 1'b0;
    endtask

    task automatic test_halt_req();
        do_reset();
        run_req = 1'b1;
        cyc();
        cyc();
        cyc();
        tests++; if (dut.cnt_q !== 2'd2) begin fails++; $display("FAIL halt_req_pre_cnt got %0d exp 2", dut.cnt_q); end
        halt_req = 1'b1;
        cyc();
        tests++; if (state !== 2'b00) begin fails++; $display("FAIL halt_req_state got %b exp 00", state); end
        tests++; if (dut.cnt_q !== 2'd0) begin fails++; $display("FAIL halt_req_cnt got %0d exp 0", dut.cnt_q); end
        tests++; if (ntick !== 0) begin fails++; $display("FAIL halt_req_ticks got %0d exp 0", ntick); end
        halt_req = 1'b0; run_req = 1'b0;
        cyc();
    endtask

    task automatic test_step();
        logic bad_state;
        do_reset();
        bad_state = 1'b0;
        for (int p = 0; p < 2; p++) begin
            step_req = 1'b1;
            for (int i = 0; i < 10; i++) begin
                if (tick && state !== 2'b10) bad_state = 1'b1;
                cyc();
            end
            step_req = 1'b0;
            cyc();
        end
        tests++; if (ntick !== 2) begin fails++; $display("FAIL step_ticks got %0d exp 2", ntick); end
        tests++; if (retired !== 8'd2) begin fails++; $display("FAIL step_retired got %0d exp 2", retired); end
        tests++; if (state !== 2'b00) begin fails++; $display("FAIL step_state got %b exp 00", state); end
        tests++; if (bad_state !== 1'b0) begin fails++; $display("FAIL step_tick_state got %b exp 0", bad_state); end
    endtask

    task automatic test_display();
        logic found;
        do_reset();
        dis_req = 1'b1; disp_add = 5'd7; inst_rs = 5'd12;
        cyc();
        tests++; if (rf_rd_addr !== 5'd7) begin fails++; $display("FAIL disp_idle_addr got %0d exp 7", rf_rd_addr); end
        step_req = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 5 && !found; i++) begin
            if (tick) begin
                found = 1'b1;
                tests++; if (rf_rd_addr !== 5'd12) begin fails++; $display("FAIL disp_tick_addr got %0d exp 12", rf_rd_addr); end
            end else begin
                cyc();
            end
        end
        tests++; if (found !== 1'b1) begin fails++; $display("FAIL disp_step_tick got %b exp 1", found); end
        cyc();
        tests++; if (rf_rd_addr !== 5'd7) begin fails++; $display("FAIL disp_return_addr got %0d exp 7", rf_rd_addr); end
        step_req = 1'b0;
        cyc();
    endtask

    task automatic test_reset_mid_step();
        logic found;
        found = 1'b0;
        step_req = 1'b1;
        for (int i = 0; i < 5 && !found; i++) begin
            if (tick) found = 1'b1;
            else cyc();
        end
        tests++; if (found !== 1'b1) begin fails++; $display("FAIL rst_step_tick got %b exp 1", found); end
        #2;
        reset = 1'b0;
        #1;
        tests++; if (tick !== 1'b0) begin fails++; $display("FAIL rst_tick got %b exp 0", tick); end
        tests++; if (state !== 2'b00) begin fails++; $display("FAIL rst_state got %b exp 00", state); end
        tests++; if (retired !== 8'd0) begin fails++; $display("FAIL rst_retired got %0d exp 0", retired); end
        @(negedge clock);
        step_req = 1'b0; dis_req = 1'b0;
        reset = 1'b1;
        cyc();
    endtask

    task automatic test_saturate();
        ntick = 0; pc = 5'd0; pc_inc = 1'b0;
        run_req = 1'b1;
        repeat (1201) cyc();
        tests++; if (ntick !== 300) begin fails++; $display("FAIL sat_ticks got %0d exp 300", ntick); end
        tests++; if (retired !== 8'd255) begin fails++; $display("FAIL sat_retired got %0d exp 255", retired); end
        run_req = 1'b0;
        cyc();
    endtask

    initial begin
        test_reset();
        test_run();
        test_last_pc();
        test_halt_req();
        test_step();
        test_display();
        test_reset_mid_step();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
